wb_commit_unit: RTL and testbench

Write-back commit unit that owns the writer side of the register file's single write port (write_enable, w_addr, w_data).
- Accepts completed results from two producers: the ALU/MAC path and the load path.
- Arbitrates between them and buffers results in a small in-order FIFO.
- Drains one register write per cycle.
- Exposes a bypass lookup so ID-stage operand reads see results that are still pending.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 92 +++++++++
 rtl/wb_commit_unit.sv | 194 +++++++++++++++++++
 tb/tb_wb_commit_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back commit unit.
//   WB_DATA_W / WB_ADDR_W : default result data and register address widths
//   REG_ZERO              : architectural zero register (writes are dropped)
//   commit_entry_t        : one pending register-file write {rd, data}
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } commit_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous in-order FIFO of commit entries. The storage array, per-entry
// valid bits and both pointers are exported so the parent can search every
// pending write for operand bypass.
//
// Ports:
//   clk, reset   : clock and synchronous active-high reset (control state only)
//   push, entry  : enqueue request and the entry to store at the tail
//   pop          : dequeue request; head is the entry at the read pointer
//   head         : current head entry
//   count        : number of occupied entries (0..DEPTH)
//   entries      : raw storage array, indexed by physical slot
//   valid        : per-slot occupancy
//   wr_ptr       : tail slot (next write), rd_ptr : head slot (next read)
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = commit_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  entry_t           entry,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output entry_t           entries [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr
);

    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] valid_next;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    // Storage holds data only; occupancy is tracked by valid/count, so the
    // array itself needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= entry;
        end
    end

    always_comb begin
        valid_next = valid;
        if (do_pop) begin
            valid_next[rd_ptr] = 1'b0;
        end
        if (do_push) begin
            valid_next[wr_ptr] = 1'b1;
        end
    end

    // Pointers are exactly PTR_W bits wide, so DEPTH being a power of two
    // makes the increment wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            valid <= valid_next;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_commit_unit.sv
// -----------------------------------------------------------------------------
// wb_commit_unit
// Write-back commit unit: owns the writer side of the register file's single
// write port. Results from the load path and the ALU/MAC path are arbitrated
// (load wins), buffered in an in-order FIFO and drained one write per cycle
// through a registered write port. A combinational bypass search lets the ID
// stage see results that have not reached the register file yet.
//
// Configuration macro: WB_BYPASS_EN
//   defined   : three bypass lookups search the output register and the FIFO
//   undefined : search removed, byp_hit*/byp_data* tied to zero
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   alu_valid/ready/rd/data         : ALU/MAC result handshake
//   ld_valid/ready/rd/data          : load result handshake
//   write_enable, w_addr, w_data    : registered register-file write port
//   fifo_count                      : occupied FIFO entries
//   busy                            : pending or in-progress write exists
//   byp_addr1..3 / byp_hit1..3 /
//   byp_data1..3                    : operand bypass lookups
// -----------------------------------------------------------------------------
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_W-1:0]        ld_rd,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     write_enable,
    output logic [ADDR_W-1:0]        w_addr,
    output logic [DATA_W-1:0]        w_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    input  logic [ADDR_W-1:0]        byp_addr1,
    input  logic [ADDR_W-1:0]        byp_addr2,
    input  logic [ADDR_W-1:0]        byp_addr3,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic                     byp_hit3,
    output logic [DATA_W-1:0]        byp_data1,
    output logic [DATA_W-1:0]        byp_data2,
    output logic [DATA_W-1:0]        byp_data3
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ZERO_RD = ADDR_W'(REG_ZERO);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic             not_full;
    logic             push;
    logic             pop;
    entry_t           push_entry;
    entry_t           head;
    entry_t           fifo_entries [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Readiness depends only on registered occupancy and ld_valid, never on
    // alu_valid. No pass-through when full, even if the same edge pops.
    assign not_full  = (fifo_count != CNT_W'(DEPTH));
    assign ld_ready  = not_full;
    assign alu_ready = not_full && !ld_valid;

    // A handshake to the zero register completes but stores nothing.
    always_comb begin
        push_entry = '{rd: alu_rd, data: alu_data};
        push       = alu_valid && alu_ready && (alu_rd != ZERO_RD);
        if (ld_valid) begin
            push_entry = '{rd: ld_rd, data: ld_data};
            push       = ld_ready && (ld_rd != ZERO_RD);
        end
    end

    assign pop = (fifo_count != '0);

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .entry   (push_entry),
        .pop     (pop),
        .head    (head),
        .count   (fifo_count),
        .entries (fifo_entries),
        .valid   (fifo_valid),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
    );

    // ---- write-port register: head popped on this edge drives the next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable <= 1'b0;
            w_addr       <= '0;
            w_data       <= '0;
        end else begin
            write_enable <= pop;
            if (pop) begin
                w_addr <= head.rd;
                w_data <= head.data;
            end
        end
    end

    assign busy = (fifo_count != '0) || write_enable;

    logic unused_wr_ptr;
    assign unused_wr_ptr = ^wr_ptr;

`ifdef WB_BYPASS_EN
    logic [ADDR_W-1:0] look_addr [3];
    logic              look_hit  [3];
    logic [DATA_W-1:0] look_data [3];

    assign look_addr[0] = byp_addr1;
    assign look_addr[1] = byp_addr2;
    assign look_addr[2] = byp_addr3;

    // Search oldest to youngest and let later matches overwrite earlier ones:
    // output register first, then FIFO slots in age order from the head.
    // Valid slots are contiguous from rd_ptr, so the last match is youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int n = 0; n < 3; n++) begin
            look_hit[n]  = 1'b0;
            look_data[n] = '0;
            if (look_addr[n] != ZERO_RD) begin
                if (write_enable && (w_addr == look_addr[n])) begin
                    look_hit[n]  = 1'b1;
                    look_data[n] = w_data;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    idx = rd_ptr + PTR_W'(k);
                    if (fifo_valid[idx] && (fifo_entries[idx].rd == look_addr[n])) begin
                        look_hit[n]  = 1'b1;
                        look_data[n] = fifo_entries[idx].data;
                    end
                end
            end
        end
    end

    assign byp_hit1  = look_hit[0];
    assign byp_hit2  = look_hit[1];
    assign byp_hit3  = look_hit[2];
    assign byp_data1 = look_data[0];
    assign byp_data2 = look_data[1];
    assign byp_data3 = look_data[2];
`else
    // Without the search, ID stalls on busy; lookup inputs and the exported
    // FIFO state are intentionally left unconsumed.
    logic [ADDR_W+DATA_W-1:0] unused_entries;
    logic                     unused_byp;

    always_comb begin
        unused_entries = '0;
        for (int k = 0; k < DEPTH; k++) begin
            unused_entries = unused_entries ^ fifo_entries[k];
        end
    end

    assign unused_byp = ^{unused_entries, fifo_valid, rd_ptr,
                          byp_addr1, byp_addr2, byp_addr3};

    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_hit3  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
    assign byp_data3 = '0;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_wb_commit_unit
// Directed stimulus for wb_commit_unit. Accepted results are queued as
// expected register-file writes; a negedge monitor pops and compares each
// write the DUT issues and tracks occupancy, busy and write timing.
// -----------------------------------------------------------------------------
module tb_wb_commit_unit;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid, ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              write_enable;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [2:0]        fifo_count;
    logic              busy;
    logic [ADDR_W-1:0] byp_addr1, byp_addr2, byp_addr3;
    logic              byp_hit1, byp_hit2, byp_hit3;
    logic [DATA_W-1:0] byp_data1, byp_data2, byp_data3;

    wb_commit_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .write_enable (write_enable),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .byp_addr1    (byp_addr1),
        .byp_addr2    (byp_addr2),
        .byp_addr3    (byp_addr3),
        .byp_hit1     (byp_hit1),
        .byp_hit2     (byp_hit2),
        .byp_hit3     (byp_hit3),
        .byp_data1    (byp_data1),
        .byp_data2    (byp_data2),
        .byp_data3    (byp_data3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   mcount   = 0;
    bit   mwe      = 1'b0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("write_enable", write_enable, mwe);
            if (write_enable) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h:%0h required=none", w_addr, w_data);
                end else begin
                    e = expq.pop_front();
                    check("w_addr", w_addr, e.rd);
                    check("w_data", w_data, e.data);
                end
            end
            check("fifo_count", fifo_count, mcount);
            check("busy", busy, (mcount != 0) || mwe);
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cyc(input bit lv, input logic [ADDR_W-1:0] lr, input logic [DATA_W-1:0] ld,
                       input bit av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad);
        bit lacc, aacc, mpush, mpop;
        exp_t e;
        ld_valid  = lv;  ld_rd  = lr; ld_data  = ld;
        alu_valid = av;  alu_rd = ar; alu_data = ad;
        @(negedge clk);
        check("ld_ready", ld_ready, mcount != DEPTH);
        check("alu_ready", alu_ready, (mcount != DEPTH) && !lv);
        @(posedge clk);
        lacc  = lv && (mcount != DEPTH);
        aacc  = av && !lv && (mcount != DEPTH);
        mpop  = (mcount > 0);
        mpush = (lacc && lr != 0) || (aacc && ar != 0);
        if (mpush) begin
            e.rd   = lacc ? lr : ar;
            e.data = lacc ? ld : ad;
            expq.push_back(e);
        end
        mwe    = mpop;
        mcount = mcount + int'(mpush) - int'(mpop);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        ld_valid = 0; alu_valid = 0;
        reset = 1'b1;
        @(posedge clk);
        expq.delete();
        mcount = 0;
        mwe    = 1'b0;
        #1;
        reset = 1'b0;
    endtask

    task automatic check_byp(input string name, input logic hit, input logic [DATA_W-1:0] data,
                             input logic req_hit, input logic [DATA_W-1:0] req_data);
        check({name, "_hit"}, hit, BYP ? req_hit : 1'b0);
        check({name, "_data"}, data, BYP ? req_data : '0);
    endtask

    initial begin
        reset = 1'b1;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        byp_addr1 = 0; byp_addr2 = 0; byp_addr3 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", write_enable, 1'b0);
        check("rst_w_addr", w_addr, 0);
        check("rst_w_data", w_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_hit1", byp_hit1, 1'b0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Single result: write visible only in the cycle after the second edge.
        cyc(0, 0, 0, 1, 7, 32'hDEADBEEF);
        check("lat_we_n", write_enable, 1'b0);
        idle(1);
        check("lat_we_n1", write_enable, 1'b1);
        check("lat_addr", w_addr, 7);
        check("lat_data", w_data, 32'hDEADBEEF);
        idle(1);
        check("lat_we_n2", write_enable, 1'b0);
        check("lat_hold_addr", w_addr, 7);
        idle(1);

        // Load beats ALU; ALU held until ld_valid drops. Order 3, 4, 5.
        cyc(1, 3, 32'h11, 1, 5, 32'h33);
        cyc(1, 4, 32'h22, 1, 5, 32'h33);
        cyc(0, 0, 0, 1, 5, 32'h33);
        idle(3);

        // Zero-register results complete the handshake but never write.
        cyc(0, 0, 0, 1, 0, 32'h55);
        check("rd0_count", fifo_count, 0);
        cyc(1, 0, 32'h66, 0, 0, 0);
        check("rd0_ld_count", fifo_count, 0);
        idle(2);

        // Back-to-back pushes across several pointer wraps, mixed sources.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) cyc(1, 5'(10 + i), 32'h1000 + i, 0, 0, 0);
            else            cyc(0, 0, 0, 1, 5'(10 + i), 32'h2000 + i);
        end
        idle(3);

        // Bypass: youngest pending match wins; address 0 never hits.
        byp_addr1 = 9; byp_addr2 = 0; byp_addr3 = 12;
        cyc(0, 0, 0, 1, 9, 32'h100);
        check_byp("byp1_a", byp_hit1, byp_data1, 1'b1, 32'h100);
        cyc(0, 0, 0, 1, 9, 32'h200);
        check_byp("byp1_b", byp_hit1, byp_data1, 1'b1, 32'h200);
        check_byp("byp2_b", byp_hit2, byp_data2, 1'b0, 0);
        check_byp("byp3_b", byp_hit3, byp_data3, 1'b0, 0);
        cyc(0, 0, 0, 1, 12, 32'h300);
        check_byp("byp1_c", byp_hit1, byp_data1, 1'b1, 32'h200);
        check_byp("byp3_c", byp_hit3, byp_data3, 1'b1, 32'h300);
        idle(1);
        check_byp("byp1_d", byp_hit1, byp_data1, 1'b0, 0);
        check_byp("byp3_d", byp_hit3, byp_data3, 1'b1, 32'h300);
        idle(1);
        check_byp("byp3_e", byp_hit3, byp_data3, 1'b0, 0);
        idle(1);

        // Reset mid-drain discards everything in flight.
        cyc(0, 0, 0, 1, 1, 32'hA1);
        cyc(0, 0, 0, 1, 2, 32'hA2);
        cyc(0, 0, 0, 1, 3, 32'hA3);
        do_reset();
        check("mid_rst_we", write_enable, 1'b0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_addr", w_addr, 0);
        idle(4);

        mon_en = 1'b0;
        check("queue_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
